// File: rtl/exec_monitor.sv
// rtl/exec_monitor.sv - breakpoint run-control and ring-buffer trace unit
// Purpose: gates the CPU clock-enable, halts on programmable PC breakpoints
//   (optionally after POST_CYCLES further cycles) and records {pc, alu} for
//   every executed cycle into a ring buffer that is read out while halted.
// Ports:
//   clk_i, rst_n_i                       clock, asynchronous active-low reset
//   cfg_we_i, cfg_idx_i, cfg_pc_i, cfg_en_i  breakpoint channel write
//   arm_i, resume_i                      run-control pulses
//   pc_in_i, alu_in_i                    live CPU PC and ALU result
//   run_en_o, halted_o                   CPU clock-enable, halted flag
//   hit_idx_o, cycle_count_o             last halting channel, executed cycles
//   trace_rd_en_i                        pop oldest trace entry (halted only)
//   trace_rd_data_o, trace_rd_valid_o    popped entry and its one-cycle strobe
//   trace_count_o                        entries currently held
module exec_monitor #(
  parameter int PC_WIDTH    = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_BP      = 4,
  parameter int POST_CYCLES = 2,
  parameter int TRACE_DEPTH = 16,
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int CNT_W = $clog2(TRACE_DEPTH) + 1,
  localparam int ENT_W = PC_WIDTH + DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cfg_we_i,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic [PC_WIDTH-1:0]   cfg_pc_i,
  input  logic                  cfg_en_i,
  input  logic                  arm_i,
  input  logic                  resume_i,
  input  logic [PC_WIDTH-1:0]   pc_in_i,
  input  logic [DATA_WIDTH-1:0] alu_in_i,
  output logic                  run_en_o,
  output logic                  halted_o,
  output logic [IDX_W-1:0]      hit_idx_o,
  output logic [31:0]           cycle_count_o,
  input  logic                  trace_rd_en_i,
  output logic [ENT_W-1:0]      trace_rd_data_o,
  output logic                  trace_rd_valid_o,
  output logic [CNT_W-1:0]      trace_count_o
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int PW    = (POST_CYCLES > 0) ? $clog2(POST_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       post_q, post_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
  logic                mask_q, mask_d;
  logic [31:0]         cycle_q;
  logic [NUM_BP-1:0]   bp_en_q;
  logic [PC_WIDTH-1:0] bp_pc_q [NUM_BP];
  logic [ENT_W-1:0]    mem_q [TRACE_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rd_valid_q;
  logic [ENT_W-1:0]    rd_data_q;

  logic                hit;
  logic [IDX_W-1:0]    hit_sel;
  logic                capture, clear, pop;

  // Breakpoint channel registers; a write is seen by the comparators next cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bp_en_q <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_pc_q[i] <= '0;
    end else if (cfg_we_i && (int'(cfg_idx_i) < NUM_BP)) begin
      bp_en_q[cfg_idx_i] <= cfg_en_i;
      bp_pc_q[cfg_idx_i] <= cfg_pc_i;
    end
  end

  // Descending scan so the lowest matching channel is the last one assigned.
  // Right after a resume the channel that caused the halt is masked for one
  // cycle so the CPU can step off the breakpoint PC.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_pc_q[i] == pc_in_i) &&
          !(mask_q && (hit_idx_q == IDX_W'(i)))) begin
        hit     = 1'b1;
        hit_sel = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    post_d    = post_q;
    hit_idx_d = hit_idx_q;
    mask_d    = 1'b0;
    capture   = 1'b0;
    clear     = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          clear     = 1'b1;
          hit_idx_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        capture = 1'b1;
        if (hit) begin
          hit_idx_d = hit_sel;
          if (POST_CYCLES == 0) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_DRAIN;
            post_d  = PW'(POST_CYCLES);
          end
        end
      end
      S_DRAIN: begin
        capture = 1'b1;
        post_d  = post_q - PW'(1);
        if (post_q <= PW'(1)) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (arm_i) begin
          clear     = 1'b1;
          hit_idx_d = '0;
          state_d   = S_RUN;
        end else begin
          pop = trace_rd_en_i && (cnt_q != '0);
          if (resume_i) begin
            state_d = S_RUN;
            mask_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      post_q     <= '0;
      hit_idx_q  <= '0;
      mask_q     <= 1'b0;
      cycle_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      post_q     <= post_d;
      hit_idx_q  <= hit_idx_d;
      mask_q     <= mask_d;
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem_q[rd_ptr_q];

      if (clear) begin
        cycle_q <= '0;
      end else if (capture) begin
        cycle_q <= cycle_q + 32'd1;
      end

      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else if (capture) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        // Full buffer: the oldest entry is overwritten, so the read side moves with it.
        if (cnt_q == CNT_W'(TRACE_DEPTH)) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        else                              cnt_q    <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cnt_q    <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Trace storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk_i) begin
    if (capture) mem_q[wr_ptr_q] <= {pc_in_i, alu_in_i};
  end

  assign run_en_o         = (state_q != S_HALTED);
  assign halted_o         = (state_q == S_HALTED);
  assign hit_idx_o        = hit_idx_q;
  assign cycle_count_o    = cycle_q;
  assign trace_rd_data_o  = rd_data_q;
  assign trace_rd_valid_o = rd_valid_q;
  assign trace_count_o    = cnt_q;

endmodule

// File: tb/tb_exec_monitor.sv
// tb/tb_exec_monitor.sv - self-checking bench for exec_monitor
module tb_exec_monitor;

  localparam int NBP   = 4;
  localparam int POST  = 2;
  localparam int DEPTH = 16;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_HALT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_en, arm, resume, trace_rd_en;
  logic [1:0]  cfg_idx;
  logic [7:0]  cfg_pc, pc_in, alu_in;
  logic        run_en, halted, trace_rd_valid;
  logic [1:0]  hit_idx;
  logic [31:0] cycle_count;
  logic [15:0] trace_rd_data;
  logic [4:0]  trace_count;
  logic        p0_run_en, p0_halted, p0_valid;
  logic [1:0]  p0_hit_idx;
  logic [31:0] p0_cycle_count;
  logic [15:0] p0_data;
  logic [4:0]  p0_trace_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_monitor #(.PC_WIDTH(8), .DATA_WIDTH(8), .NUM_BP(NBP), .POST_CYCLES(POST),
                 .TRACE_DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_pc_i(cfg_pc), .cfg_en_i(cfg_en), .arm_i(arm), .resume_i(resume),
    .pc_in_i(pc_in), .alu_in_i(alu_in), .run_en_o(run_en), .halted_o(halted),
    .hit_idx_o(hit_idx), .cycle_count_o(cycle_count), .trace_rd_en_i(trace_rd_en),
    .trace_rd_data_o(trace_rd_data), .trace_rd_valid_o(trace_rd_valid),
    .trace_count_o(trace_count));

  exec_monitor #(.PC_WIDTH(8), .DATA_WIDTH(8), .NUM_BP(NBP), .POST_CYCLES(0),
                 .TRACE_DEPTH(DEPTH)) u_dut_p0 (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_pc_i(cfg_pc), .cfg_en_i(cfg_en), .arm_i(arm), .resume_i(resume),
    .pc_in_i(pc_in), .alu_in_i(alu_in), .run_en_o(p0_run_en), .halted_o(p0_halted),
    .hit_idx_o(p0_hit_idx), .cycle_count_o(p0_cycle_count), .trace_rd_en_i(trace_rd_en),
    .trace_rd_data_o(p0_data), .trace_rd_valid_o(p0_valid),
    .trace_count_o(p0_trace_count));

  // Reference model: mode, breakpoint table and a plain queue of trace entries.
  int          m_state, m_post, m_hit;
  bit          m_mask, m_valid;
  logic [31:0] m_cyc;
  logic [15:0] m_data;
  logic [15:0] m_q[$];
  bit          m_bp_en[NBP];
  logic [7:0]  m_bp_pc[NBP];

  function automatic void model_reset();
    m_state = S_IDLE; m_post = 0; m_hit = 0; m_mask = 0; m_valid = 0;
    m_cyc = 0; m_data = 0; m_q.delete();
    for (int i = 0; i < NBP; i++) begin m_bp_en[i] = 0; m_bp_pc[i] = 0; end
  endfunction

  function automatic void model_clear();
    m_q.delete(); m_cyc = 0; m_hit = 0;
  endfunction

  function automatic void model_capture();
    m_cyc = m_cyc + 32'd1;
    m_q.push_back({pc_in, alu_in});
    if (m_q.size() > DEPTH) void'(m_q.pop_front());
  endfunction

  function automatic void model_step();
    int hs = -1;
    bit nmask = 0;
    m_valid = 0;
    case (m_state)
      S_IDLE: if (arm) begin model_clear(); m_state = S_RUN; end
      S_RUN: begin
        model_capture();
        for (int i = 0; i < NBP; i++)
          if (hs < 0 && m_bp_en[i] && m_bp_pc[i] == pc_in && !(m_mask && m_hit == i)) hs = i;
        if (hs >= 0) begin
          m_hit = hs;
          if (POST == 0) m_state = S_HALT;
          else begin m_state = S_DRAIN; m_post = POST; end
        end
      end
      S_DRAIN: begin
        model_capture();
        m_post--;
        if (m_post == 0) m_state = S_HALT;
      end
      default: begin
        if (arm) begin model_clear(); m_state = S_RUN; end
        else begin
          if (trace_rd_en && m_q.size() > 0) begin m_data = m_q.pop_front(); m_valid = 1; end
          if (resume) begin m_state = S_RUN; nmask = 1; end
        end
      end
    endcase
    m_mask = nmask;
    if (cfg_we) begin m_bp_en[cfg_idx] = cfg_en; m_bp_pc[cfg_idx] = cfg_pc; end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    check("run_en", 32'(run_en), 32'(m_state != S_HALT));
    check("halted", 32'(halted), 32'(m_state == S_HALT));
    check("hit_idx", 32'(hit_idx), 32'(m_hit));
    check("cycle_count", cycle_count, m_cyc);
    check("trace_count", 32'(trace_count), 32'(m_q.size()));
    check("rd_valid", 32'(trace_rd_valid), 32'(m_valid));
    if (m_valid) check("rd_data", 32'(trace_rd_data), 32'(m_data));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic drive_pc(input int p);
    pc_in = 8'(p); alu_in = 8'($urandom); step();
  endtask

  task automatic cfg_write(input int idx, input int pc, input bit en);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_pc = 8'(pc); cfg_en = en;
    step();
    cfg_we = 0;
  endtask

  task automatic do_arm();
    arm = 1; step(); arm = 0;
  endtask

  // Steps pc upward from start until the main unit halts; a missing halt is a failure.
  task automatic run_to_halt(input int start, input int budget);
    int p = start;
    while (!halted && p < start + budget) begin drive_pc(p); p++; end
    check("halt_timeout", 32'(halted), 32'd1);
  endtask

  initial begin
    rst_n = 0; cfg_we = 0; cfg_en = 0; cfg_idx = 0; cfg_pc = 0; arm = 0; resume = 0;
    trace_rd_en = 0; pc_in = 0; alu_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs();
    check("reset_rd_data", 32'(trace_rd_data), 32'd0);
    rst_n = 1;

    // Idle: nothing is captured or counted.
    for (int p = 0; p <= 5; p++) drive_pc(p);
    check("idle_trace_count", 32'(trace_count), 32'd0);
    check("idle_run_en", 32'(run_en), 32'd1);

    // Basic halt at pc 4 plus two drain cycles.
    cfg_write(0, 4, 1);
    do_arm();
    run_to_halt(0, 20);
    check("basic_run_en", 32'(run_en), 32'd0);
    check("basic_hit_idx", 32'(hit_idx), 32'd0);
    check("basic_cycles", cycle_count, 32'd7);
    check("basic_trace_count", 32'(trace_count), 32'd7);
    for (int k = 0; k < 7; k++) begin
      trace_rd_en = 1; step(); trace_rd_en = 0;
      check("basic_pop_pc", 32'(trace_rd_data[15:8]), 32'(k));
    end

    // Priority: ch1 and ch2 both at pc 3; disabled ch0 at pc 1 must not fire.
    cfg_write(0, 1, 0);
    cfg_write(1, 3, 1);
    cfg_write(2, 3, 1);
    do_arm();
    run_to_halt(0, 20);
    check("prio_hit_idx", 32'(hit_idx), 32'd1);
    check("prio_cycles", cycle_count, 32'd6);

    // Trace wrap: breakpoint at pc 20; the POST_CYCLES=0 unit halts right there.
    cfg_write(1, 3, 0);
    cfg_write(2, 3, 0);
    cfg_write(3, 20, 1);
    do_arm();
    for (int p = 0; p <= 20; p++) drive_pc(p);
    check("p0_halted", 32'(p0_halted), 32'd1);
    check("p0_cycles", p0_cycle_count, 32'd21);
    check("p0_trace_count", 32'(p0_trace_count), 32'd16);
    check("p0_hit_idx", 32'(p0_hit_idx), 32'd3);
    check("wrap_main_draining", 32'(halted), 32'd0);
    drive_pc(21);
    drive_pc(22);
    check("wrap_main_halted", 32'(halted), 32'd1);
    check("wrap_trace_count", 32'(trace_count), 32'd16);
    for (int k = 0; k < 16; k++) begin
      trace_rd_en = 1; step(); trace_rd_en = 0;
      check("p0_pop_valid", 32'(p0_valid), 32'd1);
      check("p0_pop_pc", 32'(p0_data[15:8]), 32'(5 + k));
      check("wrap_pop_pc", 32'(trace_rd_data[15:8]), 32'(7 + k));
      step();
      check("p0_valid_pulse", 32'(p0_valid), 32'd0);
    end
    check("p0_empty", 32'(p0_trace_count), 32'd0);
    trace_rd_en = 1; step(); trace_rd_en = 0;
    check("p0_pop_empty", 32'(p0_valid), 32'd0);
    check("pop_empty", 32'(trace_rd_valid), 32'd0);

    // Resume from a halt on the pc 4 breakpoint while pc_in still reads 4.
    cfg_write(3, 20, 0);
    cfg_write(0, 4, 1);
    cfg_write(1, 9, 1);
    do_arm();
    run_to_halt(0, 20);
    check("res_first_hit", 32'(hit_idx), 32'd0);
    pc_in = 8'd4; resume = 1; step(); resume = 0;
    drive_pc(4);
    check("res_no_rehit", 32'(halted), 32'd0);
    run_to_halt(5, 20);
    check("res_hit_idx", 32'(hit_idx), 32'd1);
    check("res_trace_count", 32'(trace_count), 32'd15);
    check("res_cycles", cycle_count, 32'd15);
    trace_rd_en = 1; step(); trace_rd_en = 0;
    check("res_oldest_pc", 32'(trace_rd_data[15:8]), 32'd0);

    // Asynchronous reset while draining.
    do_arm();
    for (int p = 0; p <= 5; p++) drive_pc(p);
    check("drain_not_halted", 32'(halted), 32'd0);
    check("drain_cycles", cycle_count, 32'd6);
    #2 rst_n = 0;
    #1;
    check("arst_run_en", 32'(run_en), 32'd1);
    check("arst_halted", 32'(halted), 32'd0);
    check("arst_hit_idx", 32'(hit_idx), 32'd0);
    check("arst_cycles", cycle_count, 32'd0);
    check("arst_trace_count", 32'(trace_count), 32'd0);
    check("arst_rd_valid", 32'(trace_rd_valid), 32'd0);
    check("arst_rd_data", 32'(trace_rd_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    drive_pc(4);
    check("post_reset_run_en", 32'(run_en), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cfg_we      = ($urandom_range(0, 15) == 0);
      cfg_idx     = 2'($urandom);
      cfg_pc      = 8'($urandom_range(0, 15));
      cfg_en      = 1'($urandom);
      arm         = ($urandom_range(0, 39) == 0);
      resume      = ($urandom_range(0, 9) == 0);
      trace_rd_en = 1'($urandom);
      pc_in       = 8'($urandom_range(0, 15));
      alu_in      = 8'($urandom);
      step();
    end
    cfg_we = 0; arm = 0; resume = 0; trace_rd_en = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_monitor.md
Name: exec_monitor

Overview:
- Hardware run-control and trace unit for the 8-bit computer.
- Compares the live PC against NUM_BP programmable breakpoints and can run POST_CYCLES extra cycles after a hit.
- Gates the CPU via run_en and records a ring-buffer trace of {pc, alu_result} per executed cycle.
- Sits beside computer; run_en drives the PC/register clock-enable, and the trace is read out while halted.

Parameters:
- PC_WIDTH, 8, program counter width.
- DATA_WIDTH, 8, ALU result width.
- NUM_BP, 4, breakpoint channels (≥1).
- POST_CYCLES, 2, cycles executed after the hit cycle before halting (0 = halt right after the hit cycle).
- TRACE_DEPTH, 16, trace entries (power of 2, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write breakpoint channel cfg_idx.
- cfg_idx  in  max(1,$clog2(NUM_BP))  channel select; out-of-range writes ignored.
- cfg_pc  in  PC_WIDTH  breakpoint address.
- cfg_en  in  1  channel enable.
- arm  in  1  start monitored run (pulse).
- resume  in  1  continue from HALTED (pulse).
- pc_in  in  PC_WIDTH  current CPU PC.
- alu_in  in  DATA_WIDTH  current ALU result.
- run_en  out  1  CPU clock-enable.
- halted  out  1  high in HALTED.
- hit_idx  out  max(1,$clog2(NUM_BP))  channel that caused the last halt.
- cycle_count  out  32  executed cycles since arm.
- trace_rd_en  in  1  pop oldest trace entry (HALTED only).
- trace_rd_data  out  PC_WIDTH+DATA_WIDTH  {pc,alu}.
- trace_rd_valid  out  1  trace_rd_data valid this cycle.
- trace_count  out  $clog2(TRACE_DEPTH)+1  entries held.

Behaviour:
- Reset:
  - State = IDLE.
  - run_en=1, halted=0, hit_idx=0, cycle_count=0, trace_count=0.
  - trace_rd_valid=0, trace_rd_data=0.
  - All channels disabled, all cfg_pc=0.
  - Reset asserted mid-run forces IDLE immediately.
- Config writes: accepted in any state and used for comparison starting the next cycle.
- IDLE:
  - run_en=1, no compare, no capture.
  - arm → RUN; trace, cycle_count and hit_idx are cleared.
- RUN:
  - run_en=1. Each cycle: cycle_count++ (wraps at 2^32) and {pc_in,alu_in} is written to the ring buffer.
  - Hit = any enabled channel with cfg_pc==pc_in. The lowest index wins and is latched into hit_idx.
  - On a hit with POST_CYCLES=0 → HALTED next edge.
  - On a hit otherwise → DRAIN with post counter = POST_CYCLES.
- DRAIN:
  - Capture and counting continue; breakpoints are ignored.
  - The counter decrements each cycle; when it reaches 0 → HALTED.
  - Net result: exactly POST_CYCLES cycles are captured after the hit cycle.
- HALTED:
  - run_en=0, halted=1, no capture, cycle_count frozen.
  - trace_rd_en with trace_count>0: next cycle trace_rd_data = oldest entry, trace_rd_valid=1, trace_count--.
  - trace_rd_en with trace_count=0: trace_rd_valid stays 0.
  - resume → RUN with the trace preserved. Channel hit_idx is masked for the first RUN cycle so the same PC does not re-halt immediately.
  - arm → RUN with trace and count cleared.
  - arm and resume in the same cycle: arm wins.
- Ignored inputs:
  - arm or resume in RUN/DRAIN.
  - resume in IDLE.
  - trace_rd_en outside HALTED.
- Ring buffer: when full, each new write overwrites the oldest entry; trace_count saturates at TRACE_DEPTH and the read pointer advances with the write.
- trace_rd_valid is a single-cycle pulse per accepted pop.

Test Plan:
- Reset then idle: run_en=1, halted=0, trace_count=0, no capture while pc_in steps 0..5.
- Basic halt:
  - Setup: ch0=pc 4 enabled, POST_CYCLES=2, arm, pc_in 0,1,2,… one per cycle.
  - Halt point: hit at pc=4, halted=1 after pc=6 is captured, run_en=0, hit_idx=0.
  - Counts: cycle_count=7, trace_count=7.
- Priority: ch1=pc 3 and ch2=pc 3 both enabled → hit_idx=1. Disabled channel ch0=pc 1 → no halt at pc=1.
- Trace wrap:
  - Setup: TRACE_DEPTH=16, bp at pc 20, POST=0, pc_in 0..20.
  - Expect trace_count=16.
  - 16 pops return pcs 5..20 in order, each pop followed one cycle later by a one-cycle trace_rd_valid pulse.
  - A 17th pop gives no valid.
- Resume:
  - From a halt at pc 4, resume while pc_in holds 4 → no re-hit on the first cycle.
  - After that, a new hit on ch1=pc 9 halts with hit_idx=1 and the trace is retained.
- Async reset in DRAIN: rst_n low between clock edges → outputs reach their reset values without waiting for a clock edge. After release, the unit is in IDLE with run_en=1.
